// File: rtl/latch_d_pkg.sv
// Shared constants for the gated D latch with its clk-domain synchronizer.
package latch_d_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
endpackage

// File: rtl/latch_d_bit.sv
// Single-bit level-sensitive latch; clr forces the stored value to 0 and overrides the gate.
module latch_d_bit (
    input  logic d,
    input  logic en,
    input  logic clr,
    output logic q
);
    always_latch begin
        if (clr) begin
            q = 1'b0;
        end else if (en) begin
            q = d;
        end
    end
endmodule

// File: rtl/latch_d_async.sv
// WIDTH-bit transparent D latch with complementary outputs, plus a clk-domain
// synchronized copy of Qa and a change pulse.
module latch_d_async
    import latch_d_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             Enable,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic [WIDTH-1:0] Q_sync,
    output logic             upd
);
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("latch_d_async: SYNC_STAGES must be within 2..4");
    end

    logic rst_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // The registered reset is the only clk influence on the latch itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        latch_d_bit u_bit (
            .d   (D[i]),
            .en  (Enable),
            .clr (rst_q),
            .q   (Qa[i])
        );
    end

    assign Qb = ~Qa;

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] q_sync_p1;

    // Synchronizer chain, then one extra register holding the previous Q_sync for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
            q_sync_p1 <= '0;
        end else begin
            sync_p[0] <= Qa;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            q_sync_p1 <= sync_p[SYNC_STAGES-1];
        end
    end

    assign Q_sync = sync_p[SYNC_STAGES-1];
    assign upd    = (Q_sync != q_sync_p1);
endmodule

// File: tb/tb_latch_d_async.sv
// Directed bench for latch_d_async at WIDTH=4: vector table for latch behaviour plus
// hand sequences for reset override, hold, synchronizer latency and short rst pulses.
module tb_latch_d_async;
    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] D;
    logic         Enable;
    logic [W-1:0] Qa;
    logic [W-1:0] Qb;
    logic [W-1:0] Q_sync;
    logic         upd;

    int checks = 0;
    int errors = 0;

    latch_d_async #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .rst    (rst),
        .D      (D),
        .Enable (Enable),
        .Qa     (Qa),
        .Qb     (Qb),
        .Q_sync (Q_sync),
        .upd    (upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         en;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b1010, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1010, 1'b1, 4'b1010};
        tbl[2]  = '{4'b1010, 1'b0, 4'b1010};
        tbl[3]  = '{4'b0101, 1'b0, 4'b1010};
        tbl[4]  = '{4'b0101, 1'b1, 4'b0101};
        tbl[5]  = '{4'b1111, 1'b1, 4'b1111};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1111};
        tbl[7]  = '{4'b0000, 1'b0, 4'b1111};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000};
        tbl[11] = '{4'b0110, 1'b1, 4'b0110};
        tbl[12] = '{4'b0110, 1'b0, 4'b0110};
        tbl[13] = '{4'b1001, 1'b0, 4'b0110};

        // Reset override: Enable and D high while reset is registered.
        rst = 1'b1; Enable = 1'b1; D = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_qa", Qa, 4'b0000);
        check("rst_qb", Qb, 4'b1111);
        check("rst_qsync", Q_sync, 4'b0000);
        check("rst_upd", {3'b000, upd}, 4'b0000);

        // Release with Enable already high: Qa takes D once rst_q drops.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_qa", Qa, 4'b1111);
        check("release_qb", Qb, 4'b0000);
        @(negedge clk);
        Enable = 1'b0;
        #1;
        D = 4'b0000;
        #2;
        check("release_hold_qa", Qa, 4'b1111);

        // Table of latch vectors starting from a cleared latch with the gate closed.
        reset_pulse();
        check("table_start_qa", Qa, 4'b0000);
        for (int i = 0; i < 14; i++) begin
            D = tbl[i].d;
            Enable = tbl[i].en;
            #2;
            check($sformatf("vec%0d_qa", i), Qa, tbl[i].exp);
            check($sformatf("vec%0d_qb", i), Qb, ~tbl[i].exp);
        end

        // Hold: D rises with the gate closed, then a gate pulse captures it.
        Enable = 1'b0; D = 4'b0000;
        reset_pulse();
        D = 4'b1111;
        #10;
        check("hold_qa", Qa, 4'b0000);
        Enable = 1'b1;
        #1;
        Enable = 1'b0;
        #2;
        check("hold_capture_qa", Qa, 4'b1111);
        check("hold_capture_qb", Qb, 4'b0000);

        // Synchronizer latency and single-cycle upd after a 0->1 change on Qa.
        D = 4'b0000;
        reset_pulse();
        repeat (SS + 1) @(negedge clk);
        check("sync_idle_qsync", Q_sync, 4'b0000);
        check("sync_idle_upd", {3'b000, upd}, 4'b0000);
        @(negedge clk);
        D = 4'b1111;
        Enable = 1'b1;
        #1;
        Enable = 1'b0;
        for (int k = 1; k <= SS + 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sync_e%0d_qsync", k), Q_sync, (k >= SS) ? 4'b1111 : 4'b0000);
            check($sformatf("sync_e%0d_upd", k), {3'b000, upd}, (k == SS) ? 4'b0001 : 4'b0000);
        end

        // An rst pulse entirely between rising edges must not disturb anything.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_qa", Qa, 4'b1111);
        check("glitch_qsync", Q_sync, 4'b1111);
        @(posedge clk);
        #1;
        check("glitch_qa_next", Qa, 4'b1111);
        check("glitch_upd", {3'b000, upd}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
